// File: rtl/pre_load_writer.sv
// Boot-time image copier: reads a byte-wide ROM from address 0, packs bytes
// little-endian into 32-bit words and writes them to SRAM over an OBI master port.
// Optional checksum output is enabled by defining PRE_LOAD_WRITER_CHECKSUM_EN.
module pre_load_writer #(
  parameter int unsigned NUM_BYTES = 100000,
  parameter logic [31:0] DEST_BASE = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic [31:0] rom_addr_o,
  input  logic [7:0]  rom_data_i,
  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  output logic [31:0] bus_addr_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_rvalid_i,
  output logic        busy_o,
  output logic        done_o
`ifdef PRE_LOAD_WRITER_CHECKSUM_EN
  ,
  output logic [31:0] checksum_o
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_WRITE,
    ST_WAIT_RSP,
    ST_DONE
  } state_t;

  // Only meaningful when NUM_BYTES > 0; the zero-length copy never reaches CAPTURE.
  localparam logic [31:0] LAST_IDX = 32'(NUM_BYTES) - 32'd1;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_cnt;
  logic [31:0] r_buf;
  logic [3:0]  r_be;
  logic [1:0]  w_lane;
  logic        w_last;
  logic        w_start;

  assign w_lane  = r_cnt[1:0];
  assign w_last  = (r_cnt == LAST_IDX);
  assign w_start = start_i && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    w_state_next = r_state;
    rom_addr_o   = '0;
    bus_req_o    = 1'b0;
    bus_we_o     = 1'b0;
    bus_addr_o   = '0;
    bus_be_o     = '0;
    bus_wdata_o  = '0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) w_state_next = (NUM_BYTES == 0) ? ST_DONE : ST_FETCH;
      end
      ST_FETCH: begin
        rom_addr_o   = r_cnt;
        busy_o       = 1'b1;
        w_state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        busy_o       = 1'b1;
        w_state_next = ((w_lane == 2'd3) || w_last) ? ST_WRITE : ST_FETCH;
      end
      ST_WRITE: begin
        bus_req_o   = 1'b1;
        bus_we_o    = 1'b1;
        bus_addr_o  = DEST_BASE + {r_cnt[31:2], 2'b00};
        bus_be_o    = r_be;
        bus_wdata_o = r_buf;
        busy_o      = 1'b1;
        if (bus_gnt_i) w_state_next = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        busy_o = 1'b1;
        if (bus_rvalid_i) w_state_next = w_last ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        done_o = 1'b1;
        if (start_i) w_state_next = (NUM_BYTES == 0) ? ST_DONE : ST_FETCH;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_buf   <= '0;
      r_be    <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start) begin
            r_cnt <= '0;
            r_buf <= '0;
            r_be  <= '0;
          end
        end
        ST_CAPTURE: begin
          r_buf[{w_lane, 3'b000} +: 8] <= rom_data_i;
          r_be[w_lane]                 <= 1'b1;
          if (!((w_lane == 2'd3) || w_last)) r_cnt <= r_cnt + 32'd1;
        end
        ST_WAIT_RSP: begin
          // Counter stays on the final byte index so the last word keeps its address.
          if (bus_rvalid_i && !w_last) begin
            r_cnt <= r_cnt + 32'd1;
            r_buf <= '0;
            r_be  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PRE_LOAD_WRITER_CHECKSUM_EN
  logic [31:0] r_csum;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_csum <= '0;
    end else if (w_start) begin
      r_csum <= '0;
    end else if (r_state == ST_CAPTURE) begin
      r_csum <= r_csum + {24'd0, rom_data_i};
    end
  end

  assign checksum_o = r_csum;
`endif

endmodule

// File: tb/tb_pre_load_writer.sv
// Directed bench for pre_load_writer: four instances (8, 5, 0 and 16 bytes) each with
// its own ROM model and OBI responder whose grant and response delays are adjustable.
module tb_pre_load_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned NB   = (g == 0) ? 8 : (g == 1) ? 5 : (g == 2) ? 0 : 16;
    localparam logic [31:0] BASE = (g == 0) ? 32'h1000 : (g == 1) ? 32'h2000 :
                                   (g == 2) ? 32'h0 : 32'h3000;
    logic        start = 1'b0;
    logic        gnt, rvalid, req, we, busy, done;
    logic [31:0] rom_addr, addr, wdata;
    logic [3:0]  be;
    logic [7:0]  rom_data;
    logic [7:0]  rom [32];
    int          gnt_delay = 0;
    int          rsp_delay = 0;
    int          wait_cnt = 0;
    int          rcnt = 0;
    logic        pend = 1'b0;
    int          req_cycles = 0;
    int          wr_n = 0;
    logic [31:0] wr_addr [8];
    logic [31:0] wr_data [8];
    logic [3:0]  wr_be [8];
`ifdef PRE_LOAD_WRITER_CHECKSUM_EN
    logic [31:0] csum;
`endif

    pre_load_writer #(.NUM_BYTES(NB), .DEST_BASE(BASE)) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .rom_addr_o  (rom_addr),
      .rom_data_i  (rom_data),
      .bus_req_o   (req),
      .bus_gnt_i   (gnt),
      .bus_addr_o  (addr),
      .bus_we_o    (we),
      .bus_be_o    (be),
      .bus_wdata_o (wdata),
      .bus_rvalid_i(rvalid),
      .busy_o      (busy),
      .done_o      (done)
`ifdef PRE_LOAD_WRITER_CHECKSUM_EN
      ,
      .checksum_o  (csum)
`endif
    );

    always @(posedge clk) rom_data <= rom[rom_addr[4:0]];

    assign gnt = req && (wait_cnt >= gnt_delay);

    always @(posedge clk) begin
      if (rst) begin
        wait_cnt <= 0;
        pend     <= 1'b0;
        rcnt     <= 0;
        rvalid   <= 1'b0;
      end else begin
        rvalid   <= 1'b0;
        wait_cnt <= (req && !gnt) ? wait_cnt + 1 : 0;
        if (req && gnt) begin
          if (rsp_delay == 0) rvalid <= 1'b1;
          else begin
            pend <= 1'b1;
            rcnt <= 1;
          end
        end else if (pend) begin
          if (rcnt >= rsp_delay) begin
            rvalid <= 1'b1;
            pend   <= 1'b0;
          end else rcnt <= rcnt + 1;
        end
      end
      if (req) req_cycles <= req_cycles + 1;
      if (req && gnt && wr_n < 8) begin
        wr_addr[wr_n] <= addr;
        wr_data[wr_n] <= wdata;
        wr_be[wr_n]   <= be;
        wr_n          <= wr_n + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    total++;
    if ({g_dut[0].rom_addr, g_dut[0].req, g_dut[0].we, g_dut[0].addr, g_dut[0].be,
         g_dut[0].wdata, g_dut[0].busy, g_dut[0].done} !== '0) begin
      bad++;
      $display("FAIL reset_outputs_dut0: got addr=%h req=%b be=%h wdata=%h busy=%b done=%b expected all 0",
               g_dut[0].addr, g_dut[0].req, g_dut[0].be, g_dut[0].wdata, g_dut[0].busy, g_dut[0].done);
    end
    total++;
    if ({g_dut[3].rom_addr, g_dut[3].req, g_dut[3].busy, g_dut[3].done} !== '0) begin
      bad++;
      $display("FAIL reset_outputs_dut3: got rom_addr=%h req=%b busy=%b done=%b expected all 0",
               g_dut[3].rom_addr, g_dut[3].req, g_dut[3].busy, g_dut[3].done);
    end
    rst = 1'b0;
    tick();
    tick();
    total++;
    if ({g_dut[0].busy, g_dut[0].done, g_dut[2].busy, g_dut[2].done} !== 4'b0000) begin
      bad++;
      $display("FAIL idle_after_reset: got %b expected 0000",
               {g_dut[0].busy, g_dut[0].done, g_dut[2].busy, g_dut[2].done});
    end
  endtask

  task automatic test_eight();
    int   t;
    int   t_req;
    logic prev_busy;
    g_dut[0].start = 1'b1;
    tick();
    g_dut[0].start = 1'b0;
    total++;
    if ({g_dut[0].busy, g_dut[0].done, g_dut[0].rom_addr} !== {2'b10, 32'd0}) begin
      bad++;
      $display("FAIL eight_first_fetch: got busy=%b done=%b rom_addr=%h expected 1 0 0",
               g_dut[0].busy, g_dut[0].done, g_dut[0].rom_addr);
    end
    t = 0;
    t_req = -1;
    prev_busy = 1'b1;
    while (!g_dut[0].done && t < 200) begin
      if (t == 2) begin
        total++;
        if (g_dut[0].rom_addr !== 32'd1) begin
          bad++;
          $display("FAIL eight_rom_addr1: got %h expected 00000001", g_dut[0].rom_addr);
        end
      end
      if (g_dut[0].req && t_req < 0) t_req = t;
      prev_busy = g_dut[0].busy;
      tick();
      t++;
    end
    total++;
    if (t != 20) begin
      bad++;
      $display("FAIL eight_done_latency: got %0d cycles expected 20", t);
    end
    total++;
    if (t_req != 8) begin
      bad++;
      $display("FAIL eight_first_req_latency: got %0d expected 8", t_req);
    end
    total++;
    if ({prev_busy, g_dut[0].busy, g_dut[0].done} !== 3'b101) begin
      bad++;
      $display("FAIL eight_busy_done_handover: got %b expected 101",
               {prev_busy, g_dut[0].busy, g_dut[0].done});
    end
    total++;
    if (g_dut[0].wr_n != 2) begin
      bad++;
      $display("FAIL eight_write_count: got %0d expected 2", g_dut[0].wr_n);
    end
    total++;
    if ({g_dut[0].wr_addr[0], g_dut[0].wr_be[0], g_dut[0].wr_data[0]} !== {32'h1000, 4'hF, 32'h04030201}) begin
      bad++;
      $display("FAIL eight_word0: got addr=%h be=%h data=%h expected 00001000 f 04030201",
               g_dut[0].wr_addr[0], g_dut[0].wr_be[0], g_dut[0].wr_data[0]);
    end
    total++;
    if ({g_dut[0].wr_addr[1], g_dut[0].wr_be[1], g_dut[0].wr_data[1]} !== {32'h1004, 4'hF, 32'h08070605}) begin
      bad++;
      $display("FAIL eight_word1: got addr=%h be=%h data=%h expected 00001004 f 08070605",
               g_dut[0].wr_addr[1], g_dut[0].wr_be[1], g_dut[0].wr_data[1]);
    end
    repeat (3) tick();
    total++;
    if ({g_dut[0].done, g_dut[0].busy} !== 2'b10) begin
      bad++;
      $display("FAIL eight_done_sticky: got done=%b busy=%b expected 1 0", g_dut[0].done, g_dut[0].busy);
    end
`ifdef PRE_LOAD_WRITER_CHECKSUM_EN
    total++;
    if (g_dut[0].csum !== 32'h24) begin
      bad++;
      $display("FAIL eight_checksum: got %h expected 00000024", g_dut[0].csum);
    end
`endif
  endtask

  task automatic test_partial();
    int t;
    g_dut[1].start = 1'b1;
    tick();
    g_dut[1].start = 1'b0;
    t = 0;
    while (!g_dut[1].done && t < 200) begin
      tick();
      t++;
    end
    total++;
    if (t != 14) begin
      bad++;
      $display("FAIL partial_done_latency: got %0d cycles expected 14", t);
    end
    total++;
    if ({g_dut[1].wr_addr[0], g_dut[1].wr_be[0], g_dut[1].wr_data[0]} !== {32'h2000, 4'hF, 32'hDDCCBBAA}) begin
      bad++;
      $display("FAIL partial_word0: got addr=%h be=%h data=%h expected 00002000 f ddccbbaa",
               g_dut[1].wr_addr[0], g_dut[1].wr_be[0], g_dut[1].wr_data[0]);
    end
    total++;
    if ({g_dut[1].wr_addr[1], g_dut[1].wr_be[1], g_dut[1].wr_data[1]} !== {32'h2004, 4'h1, 32'h000000EE}) begin
      bad++;
      $display("FAIL partial_word1: got addr=%h be=%h data=%h expected 00002004 1 000000ee",
               g_dut[1].wr_addr[1], g_dut[1].wr_be[1], g_dut[1].wr_data[1]);
    end
  endtask

  task automatic test_zero();
    g_dut[2].start = 1'b1;
    tick();
    g_dut[2].start = 1'b0;
    total++;
    if ({g_dut[2].done, g_dut[2].busy} !== 2'b10) begin
      bad++;
      $display("FAIL zero_done_next_cycle: got done=%b busy=%b expected 1 0", g_dut[2].done, g_dut[2].busy);
    end
    repeat (5) tick();
    total++;
    if (g_dut[2].req_cycles != 0 || g_dut[2].done !== 1'b1) begin
      bad++;
      $display("FAIL zero_no_request: got req_cycles=%0d done=%b expected 0 1",
               g_dut[2].req_cycles, g_dut[2].done);
    end
  endtask

  task automatic test_start_while_busy();
    int t;
    int n0;
    n0 = g_dut[1].wr_n;
    g_dut[1].start = 1'b1;
    tick();
    g_dut[1].start = 1'b0;
    total++;
    if ({g_dut[1].busy, g_dut[1].done} !== 2'b10) begin
      bad++;
      $display("FAIL restart_from_done: got busy=%b done=%b expected 1 0", g_dut[1].busy, g_dut[1].done);
    end
    t = 0;
    while (!g_dut[1].done && t < 200) begin
      g_dut[1].start = (t % 3 == 0);
      tick();
      t++;
    end
    g_dut[1].start = 1'b0;
    total++;
    if (t != 14) begin
      bad++;
      $display("FAIL busy_start_latency: got %0d cycles expected 14", t);
    end
    total++;
    if (g_dut[1].wr_n != n0 + 2) begin
      bad++;
      $display("FAIL busy_start_write_count: got %0d expected %0d", g_dut[1].wr_n, n0 + 2);
    end
    total++;
    if ({g_dut[1].wr_addr[n0+1], g_dut[1].wr_be[n0+1], g_dut[1].wr_data[n0+1]} !== {32'h2004, 4'h1, 32'h000000EE}) begin
      bad++;
      $display("FAIL busy_start_last_word: got addr=%h be=%h data=%h expected 00002004 1 000000ee",
               g_dut[1].wr_addr[n0+1], g_dut[1].wr_be[n0+1], g_dut[1].wr_data[n0+1]);
    end
`ifdef PRE_LOAD_WRITER_CHECKSUM_EN
    total++;
    if (g_dut[1].csum !== 32'h3FC) begin
      bad++;
      $display("FAIL partial_checksum: got %h expected 000003fc", g_dut[1].csum);
    end
`endif
  endtask

  task automatic test_gnt_stall();
    int   t;
    int   n;
    int   unstable;
    logic saw_rvalid;
    g_dut[3].gnt_delay = 7;
    g_dut[3].rsp_delay = 3;
    g_dut[3].start = 1'b1;
    tick();
    g_dut[3].start = 1'b0;
    t = 0;
    while (!g_dut[3].req && t < 50) begin
      tick();
      t++;
    end
    total++;
    if (t != 8) begin
      bad++;
      $display("FAIL stall_first_req_latency: got %0d expected 8", t);
    end
    n = 0;
    unstable = 0;
    while (g_dut[3].req && n < 20) begin
      if ({g_dut[3].rom_addr, g_dut[3].we, g_dut[3].addr, g_dut[3].be, g_dut[3].wdata} !==
          {32'd0, 1'b1, 32'h3000, 4'hF, 32'h13121110}) unstable++;
      n++;
      tick();
    end
    g_dut[3].gnt_delay = 0;
    total++;
    if (n != 8) begin
      bad++;
      $display("FAIL stall_req_cycles: got %0d expected 8", n);
    end
    total++;
    if (unstable != 0) begin
      bad++;
      $display("FAIL stall_request_stable: got %0d wrong cycles expected 0", unstable);
    end
    t = 0;
    saw_rvalid = 1'b0;
    while (!g_dut[3].req && t < 50) begin
      if (g_dut[3].rvalid) saw_rvalid = 1'b1;
      tick();
      t++;
    end
    total++;
    if ({saw_rvalid, 32'(t)} !== {1'b1, 32'd12}) begin
      bad++;
      $display("FAIL stall_next_write_after_rvalid: got rvalid_seen=%b gap=%0d expected 1 12", saw_rvalid, t);
    end
    total++;
    if ({g_dut[3].addr, g_dut[3].be, g_dut[3].wdata} !== {32'h3004, 4'hF, 32'h17161514}) begin
      bad++;
      $display("FAIL stall_word1: got addr=%h be=%h data=%h expected 00003004 f 17161514",
               g_dut[3].addr, g_dut[3].be, g_dut[3].wdata);
    end
  endtask

  task automatic test_reset_mid_copy();
    int t;
    int n0;
    g_dut[3].rsp_delay = 20;
    t = 0;
    while (g_dut[3].wr_n < 3 && t < 100) begin
      tick();
      t++;
    end
    total++;
    if ({g_dut[3].busy, g_dut[3].req, g_dut[3].done} !== 3'b100) begin
      bad++;
      $display("FAIL midcopy_in_wait_rsp: got busy=%b req=%b done=%b expected 1 0 0",
               g_dut[3].busy, g_dut[3].req, g_dut[3].done);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({g_dut[3].rom_addr, g_dut[3].req, g_dut[3].we, g_dut[3].addr, g_dut[3].be,
         g_dut[3].wdata, g_dut[3].busy, g_dut[3].done} !== '0) begin
      bad++;
      $display("FAIL midcopy_reset_outputs: got req=%b addr=%h be=%h wdata=%h busy=%b done=%b expected all 0",
               g_dut[3].req, g_dut[3].addr, g_dut[3].be, g_dut[3].wdata, g_dut[3].busy, g_dut[3].done);
    end
    tick();
    rst = 1'b0;
    tick();
    g_dut[3].rsp_delay = 0;
    n0 = g_dut[3].wr_n;
    g_dut[3].start = 1'b1;
    tick();
    g_dut[3].start = 1'b0;
    t = 0;
    while (!g_dut[3].done && t < 300) begin
      tick();
      t++;
    end
    total++;
    if (g_dut[3].wr_n != n0 + 4 || g_dut[3].done !== 1'b1) begin
      bad++;
      $display("FAIL restart_write_count: got %0d writes done=%b expected %0d 1",
               g_dut[3].wr_n - n0, g_dut[3].done, 4);
    end
    total++;
    if ({g_dut[3].wr_addr[n0], g_dut[3].wr_be[n0], g_dut[3].wr_data[n0]} !== {32'h3000, 4'hF, 32'h13121110}) begin
      bad++;
      $display("FAIL restart_word0: got addr=%h be=%h data=%h expected 00003000 f 13121110",
               g_dut[3].wr_addr[n0], g_dut[3].wr_be[n0], g_dut[3].wr_data[n0]);
    end
    total++;
    if ({g_dut[3].wr_addr[n0+3], g_dut[3].wr_be[n0+3], g_dut[3].wr_data[n0+3]} !== {32'h300C, 4'hF, 32'h1F1E1D1C}) begin
      bad++;
      $display("FAIL restart_word3: got addr=%h be=%h data=%h expected 0000300c f 1f1e1d1c",
               g_dut[3].wr_addr[n0+3], g_dut[3].wr_be[n0+3], g_dut[3].wr_data[n0+3]);
    end
`ifdef PRE_LOAD_WRITER_CHECKSUM_EN
    total++;
    if (g_dut[3].csum !== 32'h178) begin
      bad++;
      $display("FAIL restart_checksum: got %h expected 00000178", g_dut[3].csum);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      g_dut[0].rom[i] = 8'(i + 1);
      g_dut[1].rom[i] = 8'h00;
      g_dut[2].rom[i] = 8'h5A;
      g_dut[3].rom[i] = 8'(8'h10 + i);
    end
    g_dut[1].rom[0] = 8'hAA;
    g_dut[1].rom[1] = 8'hBB;
    g_dut[1].rom[2] = 8'hCC;
    g_dut[1].rom[3] = 8'hDD;
    g_dut[1].rom[4] = 8'hEE;

    test_reset();
    test_eight();
    test_partial();
    test_zero();
    test_start_while_busy();
    test_gnt_stall();
    test_reset_mid_copy();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
